div_result_bcd: RTL and testbench

//  Downstream stage of the 8-bit sequential divider: captures quotient/remainder when the

---
 rtl/div_result_bcd.sv | 85 ++++++++
 tb/tb_div_result_bcd.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/div_result_bcd.sv
// div_result_bcd: captures divider quotient/remainder on ready rise, converts both to packed BCD
// by double-dabble one bit per clock, and holds them behind a valid/ready handshake. Option: DIV_BCD_DROP_CNT_EN.
module div_result_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_ready,
  input  logic [WIDTH-1:0]      in_quotient,
  input  logic [WIDTH-1:0]      in_remainder,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   q_bcd,
  output logic [4*DIGITS-1:0]   r_bcd,
  output logic                  busy
`ifdef DIV_BCD_DROP_CNT_EN
  ,
  output logic [7:0]            drop_cnt
`endif
);
  localparam int BW = 4 * DIGITS;
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;
  state_t state, state_n;
  logic in_ready_d, rise, capture, done;
  logic [IW-1:0] iter;
  logic [WIDTH-1:0] q_bin, r_bin;
  logic [BW-1:0] q_acc, r_acc;
  logic [BW+WIDTH-1:0] q_step, r_step;
  function automatic logic [BW+WIDTH-1:0] dabble(input logic [BW-1:0] acc, input logic [WIDTH-1:0] bin);
    logic [BW-1:0] a;
    a = acc;
    for (int i = 0; i < DIGITS; i++)
      if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
    return {a, bin} << 1;
  endfunction
  assign rise      = in_ready & ~in_ready_d;
  // HOLD can only accept a new result in the same cycle its current one is taken
  assign capture   = rise && (state == IDLE || (state == HOLD && out_ready));
  assign done      = state == CONVERT && iter == IW'(WIDTH - 1);
  assign q_step    = dabble(q_acc, q_bin);
  assign r_step    = dabble(r_acc, r_bin);
  assign out_valid = state == HOLD;
  assign busy      = state != IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = capture ? CONVERT : done ? HOLD : (state == HOLD && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_ready_d <= 1'b0;
      iter       <= '0;
      q_bin      <= '0;
      r_bin      <= '0;
      q_acc      <= '0;
      r_acc      <= '0;
      q_bcd      <= '0;
      r_bcd      <= '0;
    end else begin
      in_ready_d <= in_ready;
      if (capture) begin
        q_bin <= in_quotient;
        r_bin <= in_remainder;
        q_acc <= '0;
        r_acc <= '0;
        iter  <= '0;
      end else if (state == CONVERT) begin
        {q_acc, q_bin} <= q_step;
        {r_acc, r_bin} <= r_step;
        iter           <= iter + 1'b1;
      end
      if (done) begin
        q_bcd <= q_step[BW+WIDTH-1 -: BW];
        r_bcd <= r_step[BW+WIDTH-1 -: BW];
      end
    end
`ifdef DIV_BCD_DROP_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) drop_cnt <= '0;
    else if (rise && !capture && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: scoreboard bench; expected BCD comes from decimal arithmetic on each issued pair.
module tb_div_result_bcd;
  logic clk = 1'b0;
  logic rst, in_ready, out_ready, out_valid, busy;
  logic [7:0] in_quotient, in_remainder;
  logic [11:0] q_bcd, r_bcd;
`ifdef DIV_BCD_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  int passed = 0, total = 0;
  logic [23:0] exp_q[$];

  div_result_bcd dut (
    .clk(clk), .rst(rst), .in_ready(in_ready), .in_quotient(in_quotient),
    .in_remainder(in_remainder), .out_valid(out_valid), .out_ready(out_ready),
    .q_bcd(q_bcd), .r_bcd(r_bcd), .busy(busy)
`ifdef DIV_BCD_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + v % 10);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int q, input int r);
    in_quotient  = 8'(q);
    in_remainder = 8'(r);
    in_ready     = 1'b1;
    exp_q.push_back({bcd(q), bcd(r)});
    tick();
    in_ready = 1'b0;
  endtask

  task automatic drain(input bit rand_ready);
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    out_ready = 1'b1;
    check("drained", exp_q.size(), 0);
    exp_q.delete();
    tick();
  endtask

  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
      else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        check("q_bcd", q_bcd, e[23:12]);
        check("r_bcd", r_bcd, e[11:0]);
      end
    end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n, pulses;
    logic prev;
    rst = 1'b1; in_ready = 1'b0; out_ready = 1'b1; in_quotient = '0; in_remainder = '0;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_q", q_bcd, 0);
    check("rst_r", r_bcd, 0);
`ifdef DIV_BCD_DROP_CNT_EN
    check("rst_drop", drop_cnt, 0);
`endif
    tick(2);
    rst = 1'b0;
    tick();
    // latency: out_valid exactly 8 edges after capture, then drops
    issue(200, 55);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("latency", n, 8);
    tick();
    check("valid_drop", out_valid, 0);
    drain(0);
    issue(255, 7); drain(0);
    issue(0, 0);   drain(0);
    // stall in HOLD
    out_ready = 1'b0;
    issue(99, 3);
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", out_valid, 1);
      check("hold_q", q_bcd, 12'h099);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("release_valid", out_valid, 0);
    check("release_busy", busy, 0);
    drain(0);
    // overrun during CONVERT is dropped
    issue(17, 4);
    tick(2);
    in_quotient = 8'd50; in_remainder = 8'd1; in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    drain(0);
    tick(12);
    check("no_second_valid", out_valid, 0);
`ifdef DIV_BCD_DROP_CNT_EN
    check("drop_cnt", drop_cnt, 1);
`endif
    // long level yields one conversion
    in_quotient = 8'd88; in_remainder = 8'd21; in_ready = 1'b1;
    exp_q.push_back({bcd(88), bcd(21)});
    pulses = 0; prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid && !prev) pulses++;
      prev = out_valid;
    end
    check("one_pulse", pulses, 1);
    in_ready = 1'b0;
    drain(0);
    // async reset mid-CONVERT
    in_quotient = 8'd123; in_remainder = 8'd45; in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    tick(4);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_q", q_bcd, 0);
    check("arst_r", r_bcd, 0);
    tick();
    rst = 1'b0;
    tick();
    issue(42, 9); drain(0);
    // randomized with random backpressure
    for (int i = 0; i < 25; i++) begin
      issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      drain(1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
